// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Request/response bundle between the CPU core and mem_port_arbiter.
//   Carries two requesters:
//     IF : instruction-fetch read port (valid/ready request, one-cycle rsp pulse)
//     LS : load/store read/write port (valid/ready request, one-cycle rsp pulse)
//   modport master : core side (drives requests, observes ready/responses)
//   modport slave  : arbiter side
interface mem_port_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rdata;

  logic        ls_req_valid;
  logic        ls_req_ready;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_rsp_valid;
  logic [31:0] ls_rdata;

  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_we, ls_addr, ls_wdata,
    input  if_req_ready, if_rsp_valid, if_rdata,
    input  ls_req_ready, ls_rsp_valid, ls_rdata
  );

  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_we, ls_addr, ls_wdata,
    output if_req_ready, if_rsp_valid, if_rdata,
    output ls_req_ready, ls_rsp_valid, ls_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous word memory port (read latency MEM_LAT >= 1)
//   between the instruction-fetch (IF, read-only) and load/store (LS)
//   requesters. One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP.
//   Request-to-response latency is MEM_LAT+1; throughput one per MEM_LAT+2.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          mem_port_arbiter_if.slave (IF and LS request/response)
//   mem_en       memory strobe, one cycle per transaction
//   mem_we       write enable (only high together with mem_en)
//   mem_addr     word index = byte address [ADDR_W+1:2] (wraps modulo DEPTH)
//   mem_wdata    write data
//   mem_rdata    read data, valid MEM_LAT cycles after mem_en
//
// Configuration macro
//   ARB_ROUND_ROBIN_EN : when defined, conflicts alternate between the
//   requesters (LS wins the first one after reset); otherwise LS always wins.
module mem_port_arbiter #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;     // 1 = LS, 0 = IF
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic idle, resp, ls_prio, grant_ls, accept;

  // Only the word-index bits of the byte addresses are meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.ls_addr[31:ADDR_W+2], bus.ls_addr[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  // last_ls_q = 1 when LS took the most recent accept; reset value is IF.
  logic last_ls_q, last_ls_d;
  assign ls_prio   = !last_ls_q;
  assign last_ls_d = accept ? grant_ls : last_ls_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_ls_q <= 1'b0;
    else        last_ls_q <= last_ls_d;
  end
`else
  assign ls_prio = 1'b1;
`endif

  assign idle     = (state_q == S_IDLE);
  assign resp     = (state_q == S_RESP);
  assign grant_ls = bus.ls_req_valid && (!bus.if_req_valid || ls_prio);

  assign bus.ls_req_ready = idle && grant_ls;
  assign bus.if_req_ready = idle && bus.if_req_valid && !grant_ls;
  assign accept           = bus.ls_req_ready || bus.if_req_ready;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d = grant_ls;
          we_d    = grant_ls && bus.ls_we;
          wdata_d = grant_ls ? bus.ls_wdata : 32'h0;
          addr_d  = grant_ls ? bus.ls_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = (MEM_LAT == 1) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = S_RESP;
      end
      default: begin  // S_RESP
        if (!we_q) begin
          if (owner_q) ls_rdata_d = mem_rdata;
          else         if_rdata_d = mem_rdata;
        end
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Memory port decodes straight from state so an async reset drops mem_en at once.
  assign mem_en    = (state_q == S_ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign bus.if_rsp_valid = resp && !owner_q;
  assign bus.ls_rsp_valid = resp && owner_q;

  // Read data is forwarded during the RESP cycle and held from the register after.
  assign bus.if_rdata = (resp && !owner_q && !we_q) ? mem_rdata : if_rdata_q;
  assign bus.ls_rdata = (resp &&  owner_q && !we_q) ? mem_rdata : ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Two instances: dut1 (MEM_LAT=1) and
//   dut3 (MEM_LAT=3), each with a behavioural word memory of matching latency.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  mem_port_arbiter_if bus1 ();
  mem_port_arbiter_if bus3 ();

  logic        m1_en, m1_we, m3_en, m3_we;
  logic [4:0]  m1_addr, m3_addr;
  logic [31:0] m1_wdata, m1_rdata, m3_wdata, m3_rdata;

  mem_port_arbiter #(.DEPTH(32), .ADDR_W(5), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr),
    .mem_wdata(m1_wdata), .mem_rdata(m1_rdata));

  mem_port_arbiter #(.DEPTH(32), .ADDR_W(5), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr),
    .mem_wdata(m3_wdata), .mem_rdata(m3_rdata));

  // Behavioural memories; pre_* lets the bench preload words.
  logic [31:0] mem1 [32];
  logic [31:0] mem3 [32];
  logic [31:0] p3_0, p3_1;
  logic        pre_we1 = 1'b0, pre_we3 = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we1) mem1[pre_addr] <= pre_data;
    if (m1_en && m1_we) mem1[m1_addr] <= m1_wdata;
    if (m1_en) m1_rdata <= mem1[m1_addr];
  end

  always @(posedge clk) begin
    if (pre_we3) mem3[pre_addr] <= pre_data;
    if (m3_en && m3_we) mem3[m3_addr] <= m3_wdata;
    if (m3_en) p3_0 <= mem3[m3_addr];
    p3_1     <= p3_0;
    m3_rdata <= p3_1;
  end

  task automatic preload(input bit which3, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d;
    if (which3) pre_we3 = 1'b1; else pre_we1 = 1'b1;
    @(negedge clk);
    pre_we1 = 1'b0; pre_we3 = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests_run++;
    if ({m1_en, m1_we, m1_addr, m1_wdata} !== 39'h0) begin
      tests_failed++; $display("FAIL reset_mem1: got %h, expected 0", {m1_en, m1_we, m1_addr, m1_wdata});
    end
    tests_run++;
    if ({bus1.if_req_ready, bus1.ls_req_ready, bus1.if_rsp_valid, bus1.ls_rsp_valid} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_hs1: got %b, expected 0000",
        {bus1.if_req_ready, bus1.ls_req_ready, bus1.if_rsp_valid, bus1.ls_rsp_valid});
    end
    tests_run++;
    if ({bus1.if_rdata, bus1.ls_rdata, bus3.if_rdata, bus3.ls_rdata} !== 128'h0) begin
      tests_failed++; $display("FAIL reset_rdata: got %h, expected 0",
        {bus1.if_rdata, bus1.ls_rdata, bus3.if_rdata, bus3.ls_rdata});
    end
    tests_run++;
    if ({m3_en, m3_we, m3_addr} !== 7'h0) begin
      tests_failed++; $display("FAIL reset_mem3: got %h, expected 0", {m3_en, m3_we, m3_addr});
    end
  endtask

  task automatic test_if_read;
    preload(1'b0, 5'd2, 32'hDEADBEEF);
    @(negedge clk); bus1.if_req_valid = 1'b1; bus1.if_addr = 32'h08; #1;
    tests_run++;
    if (bus1.if_req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL if_read_ready: got %b, expected 1", bus1.if_req_ready);
    end
    @(negedge clk); bus1.if_req_valid = 1'b0; bus1.if_addr = 32'hFFFF_FFFF; #1;
    tests_run++;
    if ({m1_en, m1_we, m1_addr} !== {1'b1, 1'b0, 5'd2}) begin
      tests_failed++; $display("FAIL if_read_issue: got en/we/addr %b/%b/%0d, expected 1/0/2", m1_en, m1_we, m1_addr);
    end
    @(negedge clk); #1;
    tests_run++;
    if ({bus1.if_rsp_valid, bus1.ls_rsp_valid, bus1.if_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      tests_failed++; $display("FAIL if_read_rsp: got rsp %b%b data %h, expected 10 deadbeef",
        bus1.if_rsp_valid, bus1.ls_rsp_valid, bus1.if_rdata);
    end
    @(negedge clk); #1;
    tests_run++;
    if ({bus1.if_rsp_valid, bus1.if_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      tests_failed++; $display("FAIL if_read_hold: got rsp %b data %h, expected 0 deadbeef", bus1.if_rsp_valid, bus1.if_rdata);
    end
  endtask

  task automatic test_ls_write;
    @(negedge clk);
    bus1.ls_req_valid = 1'b1; bus1.ls_we = 1'b1; bus1.ls_addr = 32'h14; bus1.ls_wdata = 32'h12345678; #1;
    tests_run++;
    if (bus1.ls_req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL ls_write_ready: got %b, expected 1", bus1.ls_req_ready);
    end
    @(negedge clk); bus1.ls_req_valid = 1'b0; bus1.ls_we = 1'b0; bus1.ls_wdata = 32'h0; #1;
    tests_run++;
    if ({m1_en, m1_we, m1_addr, m1_wdata} !== {1'b1, 1'b1, 5'd5, 32'h12345678}) begin
      tests_failed++; $display("FAIL ls_write_issue: got %b/%b/%0d/%h, expected 1/1/5/12345678",
        m1_en, m1_we, m1_addr, m1_wdata);
    end
    @(negedge clk); #1;
    tests_run++;
    if ({bus1.ls_rsp_valid, bus1.if_rsp_valid, bus1.ls_rdata} !== {2'b10, 32'h0}) begin
      tests_failed++; $display("FAIL ls_write_rsp: got rsp %b%b rdata %h, expected 10 00000000",
        bus1.ls_rsp_valid, bus1.if_rsp_valid, bus1.ls_rdata);
    end
    // Read the same word back through IF.
    @(negedge clk); bus1.if_req_valid = 1'b1; bus1.if_addr = 32'h14;
    @(negedge clk); bus1.if_req_valid = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if ({bus1.if_rsp_valid, bus1.if_rdata} !== {1'b1, 32'h12345678}) begin
      tests_failed++; $display("FAIL ls_write_readback: got rsp %b data %h, expected 1 12345678", bus1.if_rsp_valid, bus1.if_rdata);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    bus1.ls_req_valid = 1'b1; bus1.ls_we = 1'b1; bus1.ls_addr = 32'h84; bus1.ls_wdata = 32'hA5A50001;
    @(negedge clk); bus1.ls_req_valid = 1'b0; bus1.ls_we = 1'b0; #1;
    tests_run++;
    if ({m1_en, m1_we, m1_addr} !== {1'b1, 1'b1, 5'd1}) begin
      tests_failed++; $display("FAIL wrap_addr: got %b/%b/%0d, expected 1/1/1", m1_en, m1_we, m1_addr);
    end
    @(negedge clk);
    // Byte address 0x07 also lands on word 1 (low two bits ignored).
    @(negedge clk); bus1.ls_req_valid = 1'b1; bus1.ls_addr = 32'h07;
    @(negedge clk); bus1.ls_req_valid = 1'b0; #1;
    tests_run++;
    if (m1_addr !== 5'd1) begin
      tests_failed++; $display("FAIL wrap_lowbits: got %0d, expected 1", m1_addr);
    end
    @(negedge clk); #1;
    tests_run++;
    if ({bus1.ls_rsp_valid, bus1.ls_rdata} !== {1'b1, 32'hA5A50001}) begin
      tests_failed++; $display("FAIL wrap_readback: got rsp %b data %h, expected 1 a5a50001", bus1.ls_rsp_valid, bus1.ls_rdata);
    end
  endtask

  task automatic test_arb;
    logic [2:0] grants = 3'b000;
    logic [2:0] exp_grants;
    int n = 0;
    logic both = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_grants = 3'b101;  // grants[0]=LS, grants[1]=IF, grants[2]=LS
`else
    exp_grants = 3'b111;
`endif
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    bus1.if_req_valid = 1'b1; bus1.if_addr = 32'h0;
    bus1.ls_req_valid = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 32'h0; #1;
    for (int c = 0; c < 40; c++) begin
      if (bus1.ls_req_ready && bus1.if_req_ready) both = 1'b1;
      if (bus1.ls_req_ready || bus1.if_req_ready) begin
        grants[n] = bus1.ls_req_ready;
        n++;
      end
      if (n == 3) break;
      @(negedge clk); #1;
    end
    @(negedge clk); bus1.if_req_valid = 1'b0; bus1.ls_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (n != 3) begin
      tests_failed++; $display("FAIL arb_count: got %0d grants, expected 3", n);
    end
    tests_run++;
    if (grants !== exp_grants) begin
      tests_failed++; $display("FAIL arb_order: got %b, expected %b (bit0 first, 1=LS)", grants, exp_grants);
    end
    tests_run++;
    if (both !== 1'b0) begin
      tests_failed++; $display("FAIL arb_exclusive: both readys high together");
    end
  endtask

  task automatic test_lat3;
    preload(1'b1, 5'd7, 32'hCAFEF00D);
    @(negedge clk); bus3.if_req_valid = 1'b1; bus3.if_addr = 32'h1C; #1;
    tests_run++;
    if (bus3.if_req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL lat3_accept: got %b, expected 1", bus3.if_req_ready);
    end
    // Valid stays high: the request must wait until IDLE again.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      tests_run++;
      if ({bus3.if_req_ready, m3_en, bus3.if_rsp_valid} !== {1'b0, k == 1, k == 4}) begin
        tests_failed++; $display("FAIL lat3_t%0d: got ready/en/rsp %b/%b/%b, expected 0/%b/%b",
          k, bus3.if_req_ready, m3_en, bus3.if_rsp_valid, k == 1, k == 4);
      end
    end
    tests_run++;
    if (bus3.if_rdata !== 32'hCAFEF00D) begin
      tests_failed++; $display("FAIL lat3_rdata: got %h, expected cafef00d", bus3.if_rdata);
    end
    @(negedge clk); #1;
    tests_run++;
    if (bus3.if_req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL lat3_next_ready: got %b, expected 1", bus3.if_req_ready);
    end
    // Withdraw before accept: no transaction must follow.
    bus3.if_req_valid = 1'b0; #1;
    @(negedge clk); #1;
    tests_run++;
    if ({m3_en, bus3.if_req_ready, bus3.if_rdata} !== {2'b00, 32'hCAFEF00D}) begin
      tests_failed++; $display("FAIL lat3_withdraw: got en %b ready %b data %h, expected 0 0 cafef00d",
        m3_en, bus3.if_req_ready, bus3.if_rdata);
    end
  endtask

  task automatic test_async_reset;
    logic pulse = 1'b0;
    @(negedge clk); bus3.ls_req_valid = 1'b1; bus3.ls_we = 1'b0; bus3.ls_addr = 32'h04;
    @(negedge clk); bus3.ls_req_valid = 1'b0; #1;
    tests_run++;
    if (m3_en !== 1'b1) begin
      tests_failed++; $display("FAIL areset_issue: got mem_en %b, expected 1", m3_en);
    end
    @(negedge clk); #2;  // inside WAIT, away from any edge
    rst_n = 1'b0; #1;
    tests_run++;
    if ({m3_en, m3_we, m3_addr, bus3.if_req_ready, bus3.ls_req_ready, bus3.if_rsp_valid, bus3.ls_rsp_valid} !== 11'h0) begin
      tests_failed++; $display("FAIL areset_outputs: got %h, expected 0",
        {m3_en, m3_we, m3_addr, bus3.if_req_ready, bus3.ls_req_ready, bus3.if_rsp_valid, bus3.ls_rsp_valid});
    end
    tests_run++;
    if ({bus3.if_rdata, bus3.ls_rdata} !== 64'h0) begin
      tests_failed++; $display("FAIL areset_rdata: got %h, expected 0", {bus3.if_rdata, bus3.ls_rdata});
    end
    repeat (3) begin
      @(negedge clk); #1;
      if (bus3.ls_rsp_valid || bus3.if_rsp_valid || m3_en) pulse = 1'b1;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      if (bus3.ls_rsp_valid || bus3.if_rsp_valid || m3_en) pulse = 1'b1;
    end
    tests_run++;
    if (pulse !== 1'b0) begin
      tests_failed++; $display("FAIL areset_no_rsp: killed transaction still produced activity");
    end
    bus3.ls_req_valid = 1'b1; #1;
    tests_run++;
    if (bus3.ls_req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL areset_idle: got ready %b, expected 1", bus3.ls_req_ready);
    end
    bus3.ls_req_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    bus1.if_req_valid = 1'b0; bus1.if_addr = '0;
    bus1.ls_req_valid = 1'b0; bus1.ls_we = 1'b0; bus1.ls_addr = '0; bus1.ls_wdata = '0;
    bus3.if_req_valid = 1'b0; bus3.if_addr = '0;
    bus3.ls_req_valid = 1'b0; bus3.ls_we = 1'b0; bus3.ls_addr = '0; bus3.ls_wdata = '0;
    repeat (2) @(negedge clk);
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    test_if_read;
    test_ls_write;
    test_wrap;
    test_arb;
    test_lat3;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
